// File: rtl/serial_adder.sv
// serial_adder -- multi-cycle adder/subtractor that handles DIGIT bits per
// clock, LSB first. It uses one DIGIT-bit ripple-carry slice and a registered
// carry, and is driven through a start/done handshake.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   defined   -> ovf reports signed overflow (carry into MSB ^ carry out)
//   undefined -> ovf is tied to 0 and no MSB-carry logic is built
//
// Parameters:
//   WIDTH  operand/result width, an integer multiple of DIGIT
//   DIGIT  bits processed per cycle, 1..WIDTH
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled in IDLE or DONE
//   op     0 = a+b+cin, 1 = a-b (b inverted, carry-in forced to 1)
//   a, b   operands, captured on the accepting edge
//   cin    carry-in for add, captured on the accepting edge
//   busy   high for the N = WIDTH/DIGIT digit steps
//   done   one-cycle pulse, result valid
//   sum    result, held until the next operation's first step
//   cout   carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   ovf    signed overflow (see macro above)
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              accept_s;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              busy_r;
  logic              done_r;
  logic [DIGIT:0]    dsum_s;
  logic [WIDTH-1:0]  sum_next_s;

  // One DIGIT-bit ripple slice: x + y + c with the carry out in the top bit.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  // Next-state logic and start acceptance (IDLE or DONE only).
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Current digit through the slice, using the lowest bits of the shifters.
  always_comb begin
    dsum_s = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
  end

  // New digit enters sum from the MSB end; with DIGIT == WIDTH it is the whole result.
  generate
    if (DIGIT == WIDTH) begin : g_full
      assign sum_next_s = dsum_s[DIGIT-1:0];
    end else begin : g_part
      assign sum_next_s = {dsum_s[DIGIT-1:0], sum_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Operand capture on acceptance, one digit step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= '0;
      a_r     <= a;
      b_r     <= op ? ~b : b;
      carry_r <= op ? 1'b1 : cin;
    end else if (state_r == RUN) begin
      cnt_r   <= cnt_r + CW'(1);
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      carry_r <= dsum_s[DIGIT];
      sum_r   <= sum_next_s;
      cout_r  <= dsum_s[DIGIT];
    end
  end

  // Handshake outputs registered from the next state so they track state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_cin_s;
  logic ovf_r;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  always_comb begin
    msb_cin_s = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dsum_s[DIGIT-1];
  end

  // Overflow flag registered alongside cout; the last RUN step leaves the final value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (!accept_s && (state_r == RUN)) begin
      ovf_r <= msb_cin_s ^ dsum_s[DIGIT];
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised adder/subtractor that processes `DIGIT` bits per clock, LSB first, through one `DIGIT`-bit ripple-carry full-adder slice and a registered carry. It is the sequential successor of the team's one-bit combinational full adder. It trades latency for area on wide operands and sits behind a simple start/done handshake, so a controller or testbench can sequence it.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be an integer multiple of `DIGIT`.
- `DIGIT`, 1: bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only when not busy.
- `op`  input  1  0 = add (`a+b+cin`), 1 = subtract (`a-b`; `cin` ignored, effective carry-in = 1, `b` inverted).
- `a`  input  `WIDTH`  operand A; captured on the accepting edge.
- `b`  input  `WIDTH`  operand B; captured on the accepting edge.
- `cin`  input  1  carry-in for add; captured on the accepting edge.
- `busy`  output  1  high while digits are being processed.
- `done`  output  1  one-cycle pulse; result valid.
- `sum`  output  `WIDTH`  result; holds until the next accepted start.
- `cout`  output  1  final carry-out (for subtract: 1 = no borrow).
- `ovf`  output  1  signed overflow (see Configuration).

## Operation
- States: IDLE, RUN, DONE. `N = WIDTH/DIGIT` digit steps.
- IDLE with `start=1`: latch `a`, `b` (inverted if `op=1`), and carry (`cin`, or 1 if `op=1`). Clear the digit counter. Go to RUN.
- RUN, each cycle: add the lowest `DIGIT` bits of the A/B shift registers plus the carry register. Shift the `DIGIT`-bit result into `sum` from the MSB end. Update the carry. Shift A/B right by `DIGIT`. Increment the counter. When the counter reaches `N-1`, go to DONE.
- DONE: `done=1` for exactly this cycle.
  - `start=1` here is accepted: go straight to RUN with new operands.
  - Otherwise go to IDLE.
- `start` in RUN is ignored; no queuing.
- `sum` and `cout` change only during RUN. They are final from the DONE cycle until the first RUN step of the next operation.
- Arithmetic is modulo 2^`WIDTH`. `cout` is the carry out of bit `WIDTH-1`.
- Reset, at any point including mid-RUN: state IDLE, counter 0, `busy`/`done`/`cout`/`ovf` 0, `sum` 0. Any operation in progress is discarded without a `done` pulse.

## Timing
- Accepting edge E0 (`start` sampled in IDLE or DONE): `busy=1` from the cycle after E0 for exactly `N` cycles.
- `done=1` in the cycle after edge E0+N. Latency is `N+1` cycles from start edge to done. Throughput is one operation per `N+1` cycles with back-to-back starts.
- `busy` and `done` are never high together.
- `DIGIT=WIDTH` is legal: one RUN cycle, latency 2.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - Track the carry into the MSB slice.
  - Drive `ovf = carry_into_msb ^ cout`. It is registered with `cout` and valid in DONE. For `op=1`, this is the two's-complement overflow of `a-b`.
- Undefined: `ovf` is tied to 0 and no MSB-carry logic is built. Port list unchanged.

## Test plan
- Reset then add, `WIDTH=8`, `DIGIT=1`: `a=0x5A`, `b=0x3C`, `cin=0`, `op=0` → `busy` 8 cycles; `done` 9 cycles after start edge; `sum=0x96`, `cout=0`, `ovf=1` (macro on) / 0 (off).
- Carry wrap: `a=0xFF`, `b=0x01`, `cin=0` → `sum=0x00`, `cout=1`, `ovf=0`. Then `a=0x00`, `b=0x00`, `cin=1` → `sum=0x01`, `cout=0`.
- Subtract: `op=1`, `a=0x10`, `b=0x20`, `cin=1` → `sum=0xF0`, `cout=0` (borrow), `ovf=0`. Then `a=0x80`, `b=0x01` → `sum=0x7F`, `cout=1`, `ovf=1` (macro on).
- Handshake: pulse `start` with new operands on the 3rd busy cycle → ignored, first result unchanged. Assert `start` in the DONE cycle → next op begins, `busy` high the following cycle, no idle gap.
- Reset mid-operation: assert `rst` on the 4th RUN cycle → next cycle `busy=0`, `done=0`, `sum=0x00`, `cout=0`. No `done` pulse until a new start.
- Parameter sweep `WIDTH=16`, `DIGIT=4`: `a=0xFFFF`, `b=0x0001` → `done` 5 cycles after start edge, `sum=0x0000`, `cout=1`. Same for `DIGIT=16` → `done` after 2 cycles.
